sin_burst_ctrl: RTL and testbench
=================================

Name: sin_burst_ctrl

Overview:
- Sequencer for the quarter-wave sine generator: produces its `ce` strobe at a programmable rate.
- Runs either a counted burst of whole periods or continuous output.
- Always parks the generator at a period boundary, so output returns to the `NS` midscale with X=0 and the generator's `up`=1.
- Sits between the control/register logic and the sine generator's `ce` input; the DAC path is unchanged.

Parameters:
- DIV_W, 16, width of the rate divider value.
- CNT_W, 8, width of the burst period count.
- STEPS, 64, `ce` pulses per full sine period (4*Xmax of the generator); must be a power of two, at least 4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to begin a burst.
- stop  in  1  one-cycle request to end after the current period.
- div  in  DIV_W  rate; `ce` period = div+1 clocks; latched at accepted start.
- n_per  in  CNT_W  periods per burst, 0 = continuous; latched at accepted start.
- ce  out  1  generator step strobe, one clk wide.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when a burst ends.
- phase  out  log2(STEPS)  steps issued in the current period, 0..STEPS-1.
- per_cnt  out  CNT_W  completed periods in this burst.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ce=0, busy=0, done=0, phase=0, per_cnt=0; divider counter dcnt=0; div_q=0, n_q=0. Outputs drop immediately, mid-burst included. The generator is not reset by this block, so re-alignment after a mid-burst reset is the system's responsibility.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches div_q=div and n_q=n_per, clears dcnt, phase and per_cnt, then goes to RUN.
  - stop is ignored in IDLE; start and stop in the same cycle means start wins.
- RUN/DRAIN, divider:
  - ce is combinational: ce = (dcnt==div_q).
  - dcnt wraps to 0 when ce=1, else increments.
  - Start sampled at edge t gives first ce in cycle t+1+div_q, then every div_q+1 cycles. div_q=0 gives ce every clock.
- On each ce:
  - phase increments modulo STEPS.
  - The wrap from STEPS-1 to 0 (a period end) increments per_cnt. per_cnt wraps modulo 2^CNT_W in continuous mode.
- RUN to DONE: on a period end where n_q!=0 and per_cnt+1==n_q.
- RUN to DRAIN: on stop=1 that is not coincident with a period end.
  - stop coincident with a period end goes straight to DONE.
  - stop while already in DRAIN is ignored.
- DRAIN: ce continues; goes to DONE at the next period end. A burst-count match during DRAIN also ends at that same boundary.
- DONE: done=1 and ce=0 for exactly one cycle, then IDLE. busy=0 in DONE.
- start while busy or in DONE is ignored; div and n_per changes mid-burst have no effect.
- Invariant: the number of ce pulses from accepted start to done is always a multiple of STEPS.

Optional Feature:
- SIN_BURST_HALFSTOP_EN defined:
  - DRAIN also ends at the half-period boundary (phase wraps STEPS/2-1 to STEPS/2, the second zero crossing).
  - The generator then parks at midscale with its sign bit inverted.
  - per_cnt is not incremented at a half stop.
  - Burst-count completion is still whole periods only.
- Not defined: stops occur only at full-period boundaries, with no extra comparator logic.

Test Plan:
- Reset in IDLE: rst_n=0 → all outputs 0 asynchronously. After release with no start → ce stays 0 for 200 cycles.
- Counted burst: div=3, n_per=2, start at t → first ce at t+4, ce every 4 clocks, 128 ce total; done pulse at the cycle after the 128th ce; per_cnt=2; busy low from then on.
- Full rate: div=0, n_per=1 → ce high for 64 consecutive cycles, then done, then IDLE.
- Early stop: div=1, n_per=0, stop after 10 ce → DRAIN, exactly 64 ce total, done=1. With SIN_BURST_HALFSTOP_EN → 32 ce total, per_cnt=0.
- Stop on boundary / ignored inputs: stop in the same cycle as the 64th ce → DONE with no extra ce. start during RUN and new div mid-burst → no change in ce spacing or count.
- Reset mid-burst: rst_n=0 at ce #20 → ce, busy 0 immediately. New start after release → phase restarts at 0, full burst count honoured.

Source files
------------

// File: rtl/sin_burst_ctrl.sv
// Burst sequencer that drives the ce strobe of the quarter-wave sine generator.
// Optional half-period drain stop is enabled with `define SIN_BURST_HALFSTOP_EN.
module sin_burst_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8,
  parameter int STEPS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [DIV_W-1:0]         div,
  input  logic [CNT_W-1:0]         n_per,
  output logic                     ce,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(STEPS)-1:0] phase,
  output logic [CNT_W-1:0]         per_cnt
);

  localparam int PH_W = $clog2(STEPS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STEPS - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [DIV_W-1:0] r_dcnt;
  logic [DIV_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_n_q;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_per_cnt;

  logic             w_active;
  logic             w_ce;
  logic             w_per_end;
  logic             w_half_end;
  logic             w_cnt_hit;
  logic [CNT_W-1:0] w_per_next;

  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_ce       = w_active && (r_dcnt == r_div_q);
  assign w_per_end  = w_ce && (r_phase == PH_LAST);
  assign w_per_next = r_per_cnt + CNT_W'(1);
  assign w_cnt_hit  = w_per_end && (r_n_q != '0) && (w_per_next == r_n_q);

`ifdef SIN_BURST_HALFSTOP_EN
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(STEPS / 2 - 1);
  // Second zero crossing; the generator parks at midscale with its sign inverted.
  assign w_half_end = w_ce && (r_phase == PH_HALF);
`else
  assign w_half_end = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN: begin
        if (w_per_end && (w_cnt_hit || stop)) w_next = S_DONE;
        else if (stop)                        w_next = S_DRAIN;
      end
      S_DRAIN: if (w_per_end || w_half_end) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dcnt    <= '0;
      r_div_q   <= '0;
      r_n_q     <= '0;
      r_phase   <= '0;
      r_per_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && start) begin
        r_div_q   <= div;
        r_n_q     <= n_per;
        r_dcnt    <= '0;
        r_phase   <= '0;
        r_per_cnt <= '0;
      end else if (w_active) begin
        // Phase wraps naturally because STEPS is a power of two.
        r_dcnt <= w_ce ? '0 : r_dcnt + DIV_W'(1);
        if (w_ce)      r_phase   <= r_phase + PH_W'(1);
        if (w_per_end) r_per_cnt <= w_per_next;
      end
    end
  end

  assign ce      = w_ce;
  assign busy    = w_active;
  assign done    = (r_state == S_DONE);
  assign phase   = r_phase;
  assign per_cnt = r_per_cnt;

endmodule

// File: tb/tb_sin_burst_ctrl.sv
// Self-checking bench for sin_burst_ctrl: directed table, hand sequences and random bursts.
// Expected burst lengths come from a boundary-arithmetic model of the stop/count rules.
module tb_sin_burst_ctrl;

  localparam int STEPS  = 64;
  localparam int BUDGET = 20000;
`ifdef SIN_BURST_HALFSTOP_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] div = '0;
  logic [7:0]  n_per = '0;
  logic        ce, busy, done;
  logic [5:0]  phase;
  logic [7:0]  per_cnt;

  int checks = 0;
  int errors = 0;

  sin_burst_ctrl #(.DIV_W(16), .CNT_W(8), .STEPS(STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .div(div), .n_per(n_per),
    .ce(ce), .busy(busy), .done(done), .phase(phase), .per_cnt(per_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Burst length: first stopping boundary reached, either the n_per-th period end
  // or the boundary the stop request drains to (k = index of ce coincident with stop).
  function automatic int model_total(input int n, input int k);
    int lim, pe, he;
    lim = (n != 0) ? n * STEPS : 32'h7fffffff;
    if (k == 0 || k > lim) return lim;
    pe = ((k + STEPS - 1) / STEPS) * STEPS;
    if (HALF) begin
      he = (k / STEPS) * STEPS + STEPS / 2;
      if (he <= k) he += STEPS;
      if (he < pe) pe = he;
    end
    return (pe < lim) ? pe : lim;
  endfunction

  task automatic run_burst(input int dv, input int n, input int stop_at, input bit noise,
                           output int n_ce, output int per_d, output int ph_d,
                           output int first_idx, output bit gap_ok, output bit done_ok,
                           output bit timeout);
    int idx, last;
    n_ce = 0; per_d = -1; ph_d = -1; first_idx = -1; gap_ok = 1; done_ok = 1;
    timeout = 1; last = 0;
    @(negedge clk);
    start = 1'b1; div = 16'(dv); n_per = 8'(n); stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (idx = 1; idx < BUDGET; idx++) begin
      stop = 1'b0;
      if (done) begin
        start = 1'b0;
        per_d = int'(per_cnt); ph_d = int'(phase);
        if (ce || busy) done_ok = 0;
        @(negedge clk);
        if (done || busy || ce) done_ok = 0;
        timeout = 0;
        break;
      end
      if (ce) begin
        n_ce++;
        if (!busy) gap_ok = 0;
        if (n_ce == 1) first_idx = idx;
        else if (idx - last != dv + 1) gap_ok = 0;
        last = idx;
        if (n_ce == stop_at) stop = 1'b1;
      end
      start = 1'b0;
      if (noise && ($urandom_range(0, 7) == 0)) begin
        start = 1'b1;
        div   = 16'($urandom_range(0, 9));
        n_per = 8'($urandom_range(0, 5));
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  typedef struct {
    int dv; int n; int stop_at; bit noise; int exp_ce; int exp_per;
  } vec_t;

  task automatic do_burst(input string tag, input int dv, input int n, input int stop_at,
                          input bit noise, input int exp_ce, input int exp_per);
    int n_ce, per_d, ph_d, first_idx;
    bit gap_ok, done_ok, timeout;
    run_burst(dv, n, stop_at, noise, n_ce, per_d, ph_d, first_idx, gap_ok, done_ok, timeout);
    check({tag, " timeout"}, int'(timeout), 0);
    check({tag, " ce_total"}, n_ce, exp_ce);
    check({tag, " per_cnt"}, per_d, exp_per);
    check({tag, " phase"}, ph_d, exp_ce % STEPS);
    check({tag, " first_ce"}, first_idx, dv + 1);
    check({tag, " ce_spacing"}, int'(gap_ok), 1);
    check({tag, " done_pulse"}, int'(done_ok), 1);
  endtask

  initial begin
    vec_t tbl[7];
    int cnt, dv, n, k, tot;
    bit seen;

    tbl[0] = '{3, 2, 0,   1'b0, 128, 2};
    tbl[1] = '{0, 1, 0,   1'b0, 64,  1};
    tbl[2] = '{1, 0, 10,  1'b0, HALF ? 32 : 64, HALF ? 0 : 1};
    tbl[3] = '{2, 0, 64,  1'b1, 64,  1};
    tbl[4] = '{0, 3, 70,  1'b1, HALF ? 96 : 128, HALF ? 1 : 2};
    tbl[5] = '{1, 2, 128, 1'b0, 128, 2};
    tbl[6] = '{0, 2, 40,  1'b1, 64,  1};

    #2 rst_n = 1'b0;
    #1;
    check("rst ce", int'(ce), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst phase", int'(phase), 0);
    check("rst per_cnt", int'(per_cnt), 0);
    @(negedge clk) rst_n = 1'b1;

    cnt = 0; seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (ce) cnt++;
      if (busy || done) seen = 1;
    end
    check("idle ce", cnt, 0);
    check("idle busy_done", int'(seen), 0);

    foreach (tbl[i])
      do_burst($sformatf("vec%0d", i), tbl[i].dv, tbl[i].n, tbl[i].stop_at, tbl[i].noise,
               tbl[i].exp_ce, tbl[i].exp_per);

    // Reset in the middle of a burst, on the 20th ce.
    @(negedge clk);
    start = 1'b1; div = 16'd1; n_per = 8'd2;
    @(negedge clk);
    start = 1'b0; cnt = 0;
    for (int c = 0; c < 1000 && cnt < 20; c++) begin
      if (ce) cnt++;
      if (cnt < 20) @(negedge clk);
    end
    check("midrst reached", cnt, 20);
    rst_n = 1'b0;
    #1;
    check("midrst ce", int'(ce), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst phase", int'(phase), 0);
    check("midrst per_cnt", int'(per_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    do_burst("after_rst", 1, 2, 0, 1'b0, 128, 2);

    for (int r = 0; r < 12; r++) begin
      dv = $urandom_range(0, 3);
      n  = $urandom_range(0, 3);
      if (n == 0) k = $urandom_range(1, 200);
      else k = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, n * STEPS);
      tot = model_total(n, k);
      do_burst($sformatf("rnd%0d", r), dv, n, k, 1'b1, tot, tot / STEPS);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
